// File: rtl/one_wire_seq_ctrl.sv
// one_wire_seq_ctrl: runs reset/presence, Skip ROM, function byte, payload writes and reads as one 1-Wire transaction
module one_wire_seq_ctrl #(
  parameter logic [7:0] SKIP_ROM = 8'hCC,
  parameter int         CNT_W    = 4,
  parameter int         TMO_CYC  = 2000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_start,
  input  logic [7:0]       cmd_fn,
  input  logic [CNT_W-1:0] cmd_wr_cnt,
  input  logic [CNT_W-1:0] cmd_rd_cnt,
  output logic             cmd_ready,
  input  logic [7:0]       wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic             seq_done,
  output logic             seq_err,
  output logic [1:0]       err_code,
  output logic [1:0]       ow_op,
  output logic [7:0]       ow_tx_byte,
  output logic             ow_start,
  input  logic             ow_done,
  input  logic             ow_presence,
  input  logic [7:0]       ow_rx_byte
);
  localparam int TMO_W = (TMO_CYC > 2) ? $clog2(TMO_CYC) : 1;

  typedef enum logic [3:0] {
    IDLE, RST_REQ, RST_WAIT, ROM_REQ, ROM_WAIT, FN_REQ, FN_WAIT,
    WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, FINISH, FAIL
  } state_t;

  state_t           r_state, w_nxt, w_rd_phase;
  logic [7:0]       r_fn, r_ow_tx_byte, r_rd_data;
  logic [CNT_W-1:0] r_wr_cnt, r_rd_cnt;
  logic [TMO_W-1:0] r_tmo;
  logic [1:0]       r_ow_op, r_err;
  logic             r_ow_start, r_rd_valid;
  logic             w_wait, w_issue, w_tmo_hit;

  assign w_wait     = r_state inside {RST_WAIT, ROM_WAIT, FN_WAIT, WR_WAIT, RD_WAIT};
  assign w_issue    = (r_state inside {RST_REQ, ROM_REQ, FN_REQ, RD_REQ}) || (r_state == WR_REQ && wr_valid);
  assign w_tmo_hit  = w_wait && (r_tmo == TMO_W'(TMO_CYC - 1));
  assign w_rd_phase = (r_rd_cnt != '0) ? RD_REQ : FINISH;

  assign cmd_ready  = (r_state == IDLE);
  assign wr_ready   = (r_state == WR_REQ);
  assign seq_done   = (r_state == FINISH);
  assign seq_err    = (r_state == FAIL);
  assign rd_data    = r_rd_data;
  assign rd_valid   = r_rd_valid;
  assign err_code   = r_err;
  assign ow_op      = r_ow_op;
  assign ow_tx_byte = r_ow_tx_byte;
  assign ow_start   = r_ow_start;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nxt;
  end

  // next state: ow_done beats the timeout when both land on the same cycle
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:     w_nxt = cmd_start ? RST_REQ : IDLE;
      RST_REQ:  w_nxt = RST_WAIT;
      RST_WAIT: w_nxt = ow_done ? (ow_presence ? ROM_REQ : FAIL) : w_tmo_hit ? FAIL : RST_WAIT;
      ROM_REQ:  w_nxt = ROM_WAIT;
      ROM_WAIT: w_nxt = ow_done ? FN_REQ : w_tmo_hit ? FAIL : ROM_WAIT;
      FN_REQ:   w_nxt = FN_WAIT;
      FN_WAIT:  w_nxt = ow_done ? ((r_wr_cnt != '0) ? WR_REQ : w_rd_phase) : w_tmo_hit ? FAIL : FN_WAIT;
      WR_REQ:   w_nxt = wr_valid ? WR_WAIT : WR_REQ;
      WR_WAIT:  w_nxt = ow_done ? ((r_wr_cnt != CNT_W'(1)) ? WR_REQ : w_rd_phase) : w_tmo_hit ? FAIL : WR_WAIT;
      RD_REQ:   w_nxt = RD_WAIT;
      RD_WAIT:  w_nxt = ow_done ? ((r_rd_cnt != CNT_W'(1)) ? RD_REQ : FINISH) : w_tmo_hit ? FAIL : RD_WAIT;
      default:  w_nxt = IDLE;
    endcase
  end

  // command latch, transceiver request registers, byte counters, timeout and error capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fn         <= '0;
      r_wr_cnt     <= '0;
      r_rd_cnt     <= '0;
      r_err        <= '0;
      r_ow_start   <= 1'b0;
      r_ow_op      <= '0;
      r_ow_tx_byte <= '0;
      r_tmo        <= '0;
      r_rd_data    <= '0;
      r_rd_valid   <= 1'b0;
    end else begin
      r_ow_start <= 1'b0;
      r_rd_valid <= 1'b0;
      if (r_state == IDLE && cmd_start) begin
        r_fn     <= cmd_fn;
        r_wr_cnt <= cmd_wr_cnt;
        r_rd_cnt <= cmd_rd_cnt;
        r_err    <= '0;
      end
      if (w_issue) begin
        r_ow_start   <= 1'b1;
        r_tmo        <= '0;
        r_ow_op      <= (r_state == RST_REQ) ? 2'b00 : (r_state == RD_REQ) ? 2'b10 : 2'b01;
        r_ow_tx_byte <= (r_state == ROM_REQ) ? SKIP_ROM : (r_state == FN_REQ) ? r_fn :
                        (r_state == WR_REQ) ? wr_data : r_ow_tx_byte;
      end else if (w_wait) begin
        r_tmo <= r_tmo + 1'b1;
      end
      if (w_wait && ow_done) begin
        if (r_state == WR_WAIT) r_wr_cnt <= r_wr_cnt - 1'b1;
        if (r_state == RD_WAIT) begin
          r_rd_cnt   <= r_rd_cnt - 1'b1;
          r_rd_data  <= ow_rx_byte;
          r_rd_valid <= 1'b1;
        end
        if (r_state == RST_WAIT && !ow_presence) r_err <= 2'b01;
      end else if (w_tmo_hit) begin
        r_err <= 2'b10;
      end
    end
  end
endmodule

// File: tb/tb_one_wire_seq_ctrl.sv
// tb_one_wire_seq_ctrl: scoreboard bench with a transceiver responder and host writer
module tb_one_wire_seq_ctrl;
  localparam int TMO = 100;

  logic       clk = 1'b0, rst = 1'b1;
  logic       cmd_start = 1'b0;
  logic [7:0] cmd_fn = '0;
  logic [3:0] cmd_wr_cnt = '0, cmd_rd_cnt = '0;
  logic       cmd_ready;
  logic [7:0] wr_data = '0;
  logic       wr_valid = 1'b0, wr_ready;
  logic [7:0] rd_data;
  logic       rd_valid, seq_done, seq_err;
  logic [1:0] err_code, ow_op;
  logic [7:0] ow_tx_byte;
  logic       ow_start;
  logic       ow_done = 1'b0, ow_presence = 1'b0;
  logic [7:0] ow_rx_byte = '0;

  one_wire_seq_ctrl #(.TMO_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_fn(cmd_fn),
    .cmd_wr_cnt(cmd_wr_cnt), .cmd_rd_cnt(cmd_rd_cnt), .cmd_ready(cmd_ready),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .seq_done(seq_done), .seq_err(seq_err),
    .err_code(err_code), .ow_op(ow_op), .ow_tx_byte(ow_tx_byte), .ow_start(ow_start),
    .ow_done(ow_done), .ow_presence(ow_presence), .ow_rx_byte(ow_rx_byte)
  );

  always #5 clk = ~clk;

  // kind: 0 transceiver op, 1 read byte, 2 seq_done, 3 seq_err (op field = err_code)
  typedef struct {
    int         kind;
    logic [1:0] op;
    logic [7:0] b;
    bit         chk_b;
    int         lat;
    bit         lat_from_start;
  } ev_t;

  ev_t        sb[$];
  logic [7:0] t_wr[$], t_rd[$], rx_q[$];
  int         n_err = 0, n_chk = 0;
  int         cyc = 0, ref_cyc = 0, last_start = 0, wr_acc = 0, viol = 0;
  bit         fin_seen = 0, busy = 0, drop_rd = 0, pres_bit = 1;
  logic [1:0] rsp_op;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic void push_ev(input int kind, input logic [1:0] op, input logic [7:0] b,
                                  input bit chk_b, input int lat, input bit ls);
    ev_t e;
    e.kind = kind; e.op = op; e.b = b; e.chk_b = chk_b; e.lat = lat; e.lat_from_start = ls;
    sb.push_back(e);
  endfunction

  task automatic check_ev(input int kind, input logic [1:0] op, input logic [7:0] b);
    ev_t e;
    int  lat;
    n_chk++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_event: got kind=%0d op=%0d byte=%h, expected nothing (cyc %0d)", kind, op, b, cyc);
      return;
    end
    e = sb.pop_front();
    if (e.kind != kind || e.op != op || (e.chk_b && e.b != b)) begin
      n_err++;
      $display("FAIL event: got kind=%0d op=%0d byte=%h, expected kind=%0d op=%0d byte=%h (cyc %0d)",
               kind, op, b, e.kind, e.op, e.b, cyc);
    end
    if (e.lat != 0) begin
      lat = cyc - (e.lat_from_start ? last_start : ref_cyc);
      chk($sformatf("latency_kind%0d", kind), lat, e.lat);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    if (!rst && wr_valid && wr_ready) wr_acc++;
  end

  // monitor: pops the scoreboard whenever the DUT presents an output event
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (rd_valid) check_ev(1, 2'b00, rd_data);
      if (ow_start) begin
        check_ev(0, ow_op, ow_tx_byte);
        last_start = cyc;
      end
      if (seq_done) begin check_ev(2, err_code, 8'h00); fin_seen = 1; end
      if (seq_err)  begin check_ev(3, err_code, 8'h00); fin_seen = 1; end
      if (wr_ready && busy) viol++;
    end
  end

  // transceiver responder: random op duration, optional silence on reads
  initial forever begin
    @(negedge clk);
    if (ow_start && !rst) begin
      rsp_op = ow_op;
      busy = 1;
      repeat ($urandom_range(1, 6)) @(negedge clk);
      if (rsp_op == 2'b10 && drop_rd) busy = 0;
      else if (!rst) begin
        ow_done = 1'b1;
        ow_presence = (rsp_op == 2'b00) ? pres_bit : 1'($urandom);
        ow_rx_byte = (rsp_op == 2'b10 && rx_q.size() > 0) ? rx_q.pop_front() : 8'($urandom);
        ref_cyc = cyc;
        busy = 0;
        @(negedge clk);
        ow_done = 1'b0;
      end
    end
  end

  task automatic fill_rand(input int w, input int r);
    t_wr.delete(); t_rd.delete();
    for (int i = 0; i < w; i++) t_wr.push_back(8'($urandom));
    for (int i = 0; i < r; i++) t_rd.push_back(8'($urandom));
  endtask

  // reference model: expected transaction from the host command and the bus responses
  task automatic run_txn(input logic [7:0] fn, input bit pres, input bit drop, input int gap, input bit poke);
    int n, exp_err, v0;
    rx_q.delete();
    drop_rd = drop; pres_bit = pres; fin_seen = 0; wr_acc = 0; v0 = viol;
    push_ev(0, 2'b00, 8'h00, 0, 2, 0);
    if (!pres) begin
      push_ev(3, 2'b01, 8'h00, 0, 1, 0);
      exp_err = 1;
    end else begin
      push_ev(0, 2'b01, 8'hCC, 1, 2, 0);
      push_ev(0, 2'b01, fn, 1, 2, 0);
      for (int i = 0; i < t_wr.size(); i++) push_ev(0, 2'b01, t_wr[i], 1, 0, 0);
      if (drop && t_rd.size() > 0) begin
        push_ev(0, 2'b10, 8'h00, 0, 2, 0);
        push_ev(3, 2'b10, 8'h00, 0, TMO, 1);
        exp_err = 2;
      end else begin
        for (int i = 0; i < t_rd.size(); i++) begin
          push_ev(0, 2'b10, 8'h00, 0, 2, 0);
          push_ev(1, 2'b00, t_rd[i], 1, 1, 0);
          rx_q.push_back(t_rd[i]);
        end
        push_ev(2, 2'b00, 8'h00, 0, 1, 0);
        exp_err = 0;
      end
    end
    n = 0;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    cmd_fn = fn; cmd_wr_cnt = 4'(t_wr.size()); cmd_rd_cnt = 4'(t_rd.size());
    cmd_start = 1'b1; ref_cyc = cyc;
    @(negedge clk);
    cmd_start = 1'b0; cmd_fn = 8'($urandom); cmd_wr_cnt = 4'($urandom); cmd_rd_cnt = 4'($urandom);
    if (pres) for (int i = 0; i < t_wr.size(); i++) begin
      n = 0;
      while (!wr_ready && n < 3000) begin @(negedge clk); n++; end
      chk("wr_ready_seen", wr_ready, 1);
      if (!wr_ready) break;
      repeat (gap) @(negedge clk);
      wr_data = t_wr[i]; wr_valid = 1'b1;
      @(negedge clk);
      wr_valid = 1'b0; wr_data = 8'($urandom);
      if (poke && i == 0) begin
        cmd_fn = 8'h00; cmd_wr_cnt = 4'd0; cmd_rd_cnt = 4'd0; cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
      end
    end
    n = 0;
    while (!fin_seen && n < 3000) begin @(negedge clk); n++; end
    chk("txn_finished", fin_seen, 1);
    chk("err_code_end", err_code, exp_err);
    chk("sb_drained", sb.size(), 0);
    chk("wr_accepts", wr_acc, pres ? t_wr.size() : 0);
    chk("wr_ready_while_busy", viol - v0, 0);
    sb.delete();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_pulses", {ow_start, rd_valid, seq_done, seq_err, wr_ready}, 0);
    chk("rst_regs", {rd_data, ow_tx_byte, ow_op, err_code}, 0);
    rst = 1'b0;
    @(negedge clk);

    t_wr.delete(); t_rd.delete();
    run_txn(8'h44, 1, 0, 0, 0);

    t_wr.delete();
    t_rd = {8'h50, 8'h05, 8'h4B, 8'h46, 8'h7F, 8'hFF, 8'h0C, 8'h10, 8'h1C};
    run_txn(8'hBE, 1, 0, 0, 0);

    t_wr = {8'h7F, 8'h80, 8'h1F}; t_rd.delete();
    run_txn(8'h4E, 1, 0, 5, 1);

    t_wr = {8'h11}; t_rd = {8'h22};
    run_txn(8'h44, 0, 0, 0, 0);

    t_wr.delete(); t_rd = {8'h01, 8'h02};
    run_txn(8'hBE, 1, 1, 0, 0);

    fill_rand(15, 15);
    run_txn(8'($urandom), 1, 0, 0, 0);

    for (int k = 0; k < 8; k++) begin
      fill_rand($urandom_range(0, 4), $urandom_range(0, 4));
      run_txn(8'($urandom), $urandom_range(0, 4) != 0, 0, $urandom_range(0, 3), 1'($urandom));
    end

    // reset while waiting on a read op
    t_wr.delete(); t_rd.delete(); rx_q.delete();
    drop_rd = 1; pres_bit = 1;
    push_ev(0, 2'b00, 8'h00, 0, 2, 0);
    push_ev(0, 2'b01, 8'hCC, 1, 2, 0);
    push_ev(0, 2'b01, 8'hB4, 1, 2, 0);
    push_ev(0, 2'b10, 8'h00, 0, 2, 0);
    @(negedge clk);
    cmd_fn = 8'hB4; cmd_wr_cnt = 4'd0; cmd_rd_cnt = 4'd3; cmd_start = 1'b1; ref_cyc = cyc;
    @(negedge clk);
    cmd_start = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 500) begin @(negedge clk); n++; end
    chk("rd_op_reached", sb.size(), 0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_async_ready", cmd_ready, 1);
    chk("rst_async_start", ow_start, 0);
    @(negedge clk);
    rst = 1'b0; busy = 0; sb.delete();
    repeat (10) @(negedge clk);
    chk("post_rst_idle", {cmd_ready, err_code, ow_op}, 5'b10000);

    fill_rand(2, 2);
    run_txn(8'h5A, 1, 0, 1, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
